// File: rtl/avmm_cfg_pkg.sv
// Shared FSM state type, default widths and a counter-sizing helper for the
// Avalon-MM configuration master.
package avmm_cfg_pkg;

  localparam int unsigned DEF_REG_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RDWAIT,
    RESP
  } state_t;

  // Bits needed to hold every value 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/avmm_config_master.sv
// Single-outstanding Avalon-MM master that turns a command/response stream
// into fixed-latency register reads and writes, with a waitrequest timeout.
module avmm_config_master
  import avmm_cfg_pkg::*;
#(
  parameter int unsigned REG_WIDTH    = DEF_REG_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [REG_WIDTH-1:0]  cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [ADDR_WIDTH-1:0] avm_addr,
  output logic [REG_WIDTH-1:0]  avm_writedata,
  input  logic [REG_WIDTH-1:0]  avm_readdata,
  input  logic                  avm_waitrequest,
  output logic                  busy
);

  localparam int unsigned STALL_W = cnt_width(TIMEOUT);
  localparam int unsigned LAT_W   = cnt_width(READ_LATENCY);

  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0]   LAT_ONE    = LAT_W'(1);

  state_t state, state_nxt;

  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [REG_WIDTH-1:0]  req_wdata;
  logic [STALL_W-1:0]    stall_cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [REG_WIDTH-1:0]  rdata_q;
  logic                  err_q;

  logic cmd_fire;
  logic xfer_done;
  logic xfer_timeout;
  logic lat_done;

  assign cmd_fire     = (state == IDLE) && cmd_valid;
  assign xfer_done    = (state == REQ) && !avm_waitrequest;
  // The TIMEOUT-th stalled cycle is the last one the strobe is held.
  assign xfer_timeout = (state == REQ) && avm_waitrequest && (stall_cnt == STALL_LAST);
  assign lat_done     = (state == RDWAIT) && (lat_cnt == LAT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = REQ;
      REQ: begin
        if (xfer_done)         state_nxt = req_write ? RESP : RDWAIT;
        else if (xfer_timeout) state_nxt = RESP;
      end
      RDWAIT:  if (lat_done)  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    avm_write = 1'b0;
    avm_read  = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      REQ: begin
        avm_write = req_write;
        avm_read  = !req_write;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign avm_addr      = req_addr;
  assign avm_writedata = req_wdata;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;

  // Command capture, stall/latency counters and the response registers.
  // Response data is cleared at accept so writes and timeouts return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      stall_cnt <= '0;
      lat_cnt   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (cmd_fire) begin
        req_write <= cmd_write;
        req_addr  <= cmd_addr;
        req_wdata <= cmd_wdata;
        stall_cnt <= '0;
        rdata_q   <= '0;
        err_q     <= 1'b0;
      end
      if ((state == REQ) && avm_waitrequest && (stall_cnt != STALL_MAX))
        stall_cnt <= stall_cnt + STALL_ONE;
      if (xfer_done)
        lat_cnt <= '0;
      else if ((state == RDWAIT) && !lat_done)
        lat_cnt <= lat_cnt + LAT_ONE;
      if (lat_done)
        rdata_q <= avm_readdata;
      if (xfer_timeout)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avmm_config_master.sv
// Self-checking bench: register-file responder with controllable stalls and a
// transaction-level model of latency, data and timeout behaviour.
module tb_avmm_config_master;

  localparam int RL      = 1;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        avm_write;
  logic        avm_read;
  logic [3:0]  avm_addr;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;

  int total = 0;
  int bad   = 0;

  avmm_config_master #(
    .REG_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(RL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avm_write(avm_write), .avm_read(avm_read), .avm_addr(avm_addr),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  // Responder: 16-word register file, fixed read latency, stalls on request.
  logic [31:0] regs    [16] = '{default: '0};
  logic [31:0] rd_pipe [RL] = '{default: '0};
  int  stall_seen = 0;
  int  stall_req  = 0;
  bit  stuck      = 1'b0;
  logic i2c_sel;

  assign avm_waitrequest = (avm_write || avm_read) && (stuck || (stall_seen < stall_req));
  assign avm_readdata    = rd_pipe[RL-1];
  assign i2c_sel         = regs[0][0];

  always @(posedge clk) begin
    if (avm_write || avm_read) begin
      if (avm_waitrequest) stall_seen <= stall_seen + 1;
    end else begin
      stall_seen <= 0;
    end
    if (avm_write && !avm_waitrequest) regs[avm_addr] <= avm_writedata;
    // Garbage outside read slots exposes capture at the wrong cycle.
    rd_pipe[0] <= (avm_read && !avm_waitrequest) ? regs[avm_addr] : $urandom;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  logic [31:0] model [16] = '{default: '0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction from accept to handshake; all driving at negedge.
  task automatic do_xfer(input bit wr, input logic [3:0] a, input logic [31:0] d,
                         input int stalls, input int hold, input bit keep_valid);
    int          lat;
    int          strobes;
    bit          to;
    logic [31:0] exp_d;
    int          exp_lat;
    to      = (stalls >= TIMEOUT);
    exp_d   = (wr || to) ? 32'h0 : model[a];
    exp_lat = to ? 1 + TIMEOUT : (wr ? 2 + stalls : 2 + stalls + RL);

    check("ready_idle", cmd_ready, 1);
    stall_req = stalls;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat     = 1;
    strobes = 0;
    check("strobe_c1", avm_write | avm_read, 1);
    while (!rsp_valid && lat < 40) begin
      if (avm_write || avm_read) begin
        strobes++;
        check("strobe_wr", avm_write, wr);
        check("strobe_rd", avm_read, !wr);
        check("strobe_addr", avm_addr, a);
        if (wr) check("strobe_wdata", avm_writedata, d);
      end
      check("ready_busy", cmd_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", lat, exp_lat);
    check("strobe_cycles", strobes, to ? TIMEOUT : stalls + 1);
    check("rsp_err", rsp_err, to);
    check("rsp_rdata", rsp_rdata, exp_d);

    for (int i = 0; i < hold; i++) begin
      cmd_valid = keep_valid;
      cmd_addr  = ~a;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, exp_d);
      check("hold_err", rsp_err, to);
      check("hold_ready", cmd_ready, 0);
      check("hold_strobe", avm_write | avm_read, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("hs_ready", cmd_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_ready", cmd_ready, 1);
    if (wr && !to) model[a] = d;
    stall_req = 0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wr", avm_write, 0);
    check("rst_rd", avm_read, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_err", rsp_err, 0);
    check("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write 1 to address 0 selects i2c.
    check("i2c_before", i2c_sel, 0);
    do_xfer(1'b1, 4'h0, 32'h1, 0, 0, 1'b0);
    check("i2c_sel", i2c_sel, 1);

    // Write then read back.
    do_xfer(1'b1, 4'h5, 32'hDEADBEEF, 0, 0, 1'b0);
    do_xfer(1'b0, 4'h5, 32'h0, 0, 0, 1'b0);

    // Read stalled for three cycles.
    do_xfer(1'b0, 4'h5, 32'h0, 3, 0, 1'b0);

    // Stuck waitrequest times out.
    do_xfer(1'b0, 4'h5, 32'h0, 50, 0, 1'b0);
    do_xfer(1'b1, 4'h7, 32'h12345678, 50, 0, 1'b0);

    // Backpressured response with another command waiting.
    do_xfer(1'b0, 4'h0, 32'h0, 1, 10, 1'b1);

    // Reset during a stalled request.
    stuck = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_rd", avm_read, 1);
    @(negedge clk);
    check("mid_wait", avm_waitrequest, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_rd", avm_read, 0);
    check("mrst_wr", avm_write, 0);
    check("mrst_valid", rsp_valid, 0);
    check("mrst_ready", cmd_ready, 1);
    check("mrst_busy", busy, 0);
    rst   = 1'b0;
    stuck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mrst_idle_valid", rsp_valid, 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      do_xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avmm_config_master.md
AVMM_CONFIG_MASTER -- requirements
Module: avmm_config_master

Interface
REQ-001 Parameter REG_WIDTH, default 32, SHALL set the Avalon-MM data width and the command/response data width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the Avalon-MM word-address width.
REQ-003 Parameter READ_LATENCY, default 1, legal range >=1, SHALL set the fixed responder read latency in cycles.
REQ-004 Parameter TIMEOUT, default 255, legal range >=1, SHALL set the maximum number of waitrequest-stalled cycles per transfer.
REQ-005 Port clk, input, 1 bit: single clock; all logic SHALL be rising-edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port cmd_valid, input, 1 bit: a command is offered.
REQ-008 Port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-009 Port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-010 Port cmd_addr, input, ADDR_WIDTH bits: target word address.
REQ-011 Port cmd_wdata, input, REG_WIDTH bits: write data.
REQ-012 Port rsp_valid, output, 1 bit: a response is presented.
REQ-013 Port rsp_ready, input, 1 bit: the consumer takes the response.
REQ-014 Port rsp_rdata, output, REG_WIDTH bits: read data (0 for writes and errors).
REQ-015 Port rsp_err, output, 1 bit: the transfer timed out.
REQ-016 Port avm_write / avm_read, output, 1 bit each: Avalon-MM write and read strobes.
REQ-017 Port avm_addr, output, ADDR_WIDTH bits; port avm_writedata, output, REG_WIDTH bits.
REQ-018 Port avm_readdata, input, REG_WIDTH bits; port avm_waitrequest, input, 1 bit (tie 0 for responders without stall).
REQ-019 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, REQ, RDWAIT and RESP, with one transfer outstanding at most.
REQ-021 IDLE: cmd_ready=1; on cmd_valid, the block SHALL register cmd_write/addr/wdata and enter REQ.
REQ-022 cmd_ready SHALL be 0 in REQ, RDWAIT and RESP.
REQ-023 REQ: exactly one of avm_write/avm_read SHALL be 1, and addr/writedata SHALL stay stable while avm_waitrequest=1.
REQ-024 A transfer SHALL complete in the first REQ cycle with avm_waitrequest=0; the strobe SHALL drop the next cycle.
REQ-025 A completed write SHALL go to RESP with rsp_rdata=0 and rsp_err=0.
REQ-026 A completed read SHALL go to RDWAIT, count READ_LATENCY cycles, capture avm_readdata at the end of the READ_LATENCY-th cycle after completion, then enter RESP.
REQ-027 Latency with no stall SHALL be: accept at cycle 0, strobe at cycle 1, write rsp_valid at cycle 2, read rsp_valid at cycle 2+READ_LATENCY.
REQ-028 A saturating stall counter SHALL clear on entering REQ and increment on each REQ cycle with avm_waitrequest=1.
REQ-029 When the stall counter reaches TIMEOUT, the block SHALL drop the strobe the next cycle, enter RESP with rsp_err=1 and rsp_rdata=0, and ignore later readdata.
REQ-030 RESP: rsp_valid=1 with data and err held stable until rsp_ready=1, then the block SHALL return to IDLE.
REQ-031 A new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-032 A stall counter wide enough for TIMEOUT SHALL not wrap.

Reset
REQ-033 While rst=1, the block SHALL enter IDLE, and all outputs except cmd_ready SHALL be 0 from the next edge, with cmd_ready=1 after reset.
REQ-034 A reset mid-transfer SHALL deassert the strobes at the next edge and discard captured data and any pending response.

Structure
REQ-035 Package avmm_cfg_pkg SHALL hold the FSM state enum and the default REG_WIDTH/ADDR_WIDTH constants.
REQ-036 The block SHALL be a single module with no sub-module; the stall and latency counters are inline.

Verification
REQ-037 Write 0x1 to addr 0x0 against the register-file responder -> avm_write=1 at cycle 1, rsp_valid at cycle 2, and the i2c_sel output becomes 1.
REQ-038 Write 0xDEADBEEF to addr 0x5, then read addr 0x5 (READ_LATENCY=1) -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at cycle 3 after accept.
REQ-039 Read with avm_waitrequest held for 3 cycles -> strobe and addr stable for 4 cycles, response 1+3+1+READ_LATENCY cycles after accept.
REQ-040 avm_waitrequest stuck at 1 with TIMEOUT=4 -> strobe dropped after 4 stalled cycles, rsp_err=1, rsp_rdata=0.
REQ-041 rsp_ready held at 0 for 10 cycles with a new cmd_valid present -> rsp_valid and data held, cmd_ready=0, no second strobe issued.
REQ-042 rst pulse during REQ with waitrequest=1 -> strobe 0 after the next edge, no rsp_valid, cmd_ready=1, busy=0.
